// File: rtl/id_entry_ctrl.sv
// Mode/sequence controller for 8-digit student-ID entry: owns edit buffer, cursor and
// stored ID, and drives the registered digit/blank bus for the 7-seg scan driver.
module id_entry_ctrl #(
    parameter int DIGITS     = 8,
    parameter int SCROLL_DIV = 50_000_000
) (
    input  logic        clk100mhz,
    input  logic        clr,
    input  logic        key_wei_p,
    input  logic        key_shuzi_p,
    input  logic        key_enter_p,
    input  logic        key_input_p,
    input  logic        key_disp_p,
    output logic [31:0] disp_digits,
    output logic [7:0]  blank,
    output logic [2:0]  cursor,
    output logic [1:0]  mode,
    output logic        id_valid
);

    localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_INPUT = 2'b01,
        ST_DISP  = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_INPUT = 3'd1,
        ACT_ENTER = 3'd2,
        ACT_DISP  = 3'd3,
        ACT_WEI   = 3'd4,
        ACT_SHUZI = 3'd5
    } act_t;

    // BCD digit increment, 9 wraps to 0 so A-F can never appear
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd9) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Rotate left by k nibbles: nibble 7 wraps round to position 0
    function automatic logic [31:0] rotl_nibbles(input logic [31:0] v, input logic [2:0] k);
        logic [63:0] tmp;
        tmp = {v, v} << {k, 2'b00};
        return tmp[63:32];
    endfunction

    state_t           state_r, state_s;
    act_t             act_s;
    logic [31:0]      edit_r, edit_s;
    logic [31:0]      id_r, id_s;
    logic             id_valid_r, id_valid_s;
    logic [2:0]       cursor_r, cursor_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       offset_r, offset_s;
    logic [31:0]      digits_s;
    logic [7:0]       blank_s;

    // Single action per cycle, highest-priority key wins
    always_comb begin
        act_s = ACT_NONE;
        if (key_input_p) begin
            act_s = ACT_INPUT;
        end else if (key_enter_p) begin
            act_s = ACT_ENTER;
        end else if (key_disp_p) begin
            act_s = ACT_DISP;
        end else if (key_wei_p) begin
            act_s = ACT_WEI;
        end else if (key_shuzi_p) begin
            act_s = ACT_SHUZI;
        end else begin
            act_s = ACT_NONE;
        end
    end

    // State register
    always_ff @(posedge clk100mhz) begin
        if (clr) begin
            state_r    <= ST_IDLE;
            edit_r     <= 32'h0;
            id_r       <= 32'h0;
            id_valid_r <= 1'b0;
            cursor_r   <= 3'd7;
            cnt_r      <= '0;
            offset_r   <= 3'd0;
        end else begin
            state_r    <= state_s;
            edit_r     <= edit_s;
            id_r       <= id_s;
            id_valid_r <= id_valid_s;
            cursor_r   <= cursor_s;
            cnt_r      <= cnt_s;
            offset_r   <= offset_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s    = state_r;
        edit_s     = edit_r;
        id_s       = id_r;
        id_valid_s = id_valid_r;
        cursor_s   = cursor_r;
        cnt_s      = cnt_r;
        offset_s   = offset_r;
        case (state_r)
            ST_IDLE: begin
                if (act_s == ACT_INPUT) begin
                    state_s  = ST_INPUT;
                    edit_s   = 32'h0;
                    cursor_s = 3'd7;
                end else if (act_s == ACT_DISP && id_valid_r) begin
                    state_s  = ST_DISP;
                    cnt_s    = '0;
                    offset_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INPUT: begin
                case (act_s)
                    ACT_INPUT: begin
                        edit_s   = 32'h0;
                        cursor_s = 3'd7;
                    end
                    ACT_ENTER: begin
                        id_s       = edit_r;
                        id_valid_s = 1'b1;
                        state_s    = ST_IDLE;
                    end
                    ACT_WEI: begin
                        cursor_s = cursor_r - 3'd1;
                    end
                    ACT_SHUZI: begin
                        edit_s[{cursor_r, 2'b00} +: 4] = bcd_inc(edit_r[{cursor_r, 2'b00} +: 4]);
                    end
                    default: begin
                        state_s = ST_INPUT;
                    end
                endcase
            end
            ST_DISP: begin
                if (cnt_r == CNT_TERM) begin
                    cnt_s    = '0;
                    offset_s = offset_r + 3'd1;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (act_s == ACT_INPUT) begin
                    state_s  = ST_INPUT;
                    edit_s   = 32'h0;
                    cursor_s = 3'd7;
                end else if (act_s == ACT_DISP) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DISP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from current state
    always_comb begin
        digits_s = 32'h0;
        blank_s  = 8'hFF;
        case (state_r)
            ST_IDLE: begin
                digits_s = 32'h0;
                blank_s  = 8'hFF;
            end
            ST_INPUT: begin
                digits_s = edit_r;
                blank_s  = 8'h00;
            end
            ST_DISP: begin
                digits_s = rotl_nibbles(id_r, offset_r);
                blank_s  = 8'h00;
            end
            default: begin
                digits_s = 32'h0;
                blank_s  = 8'hFF;
            end
        endcase
    end

    // Output registers, one cycle behind the state registers
    always_ff @(posedge clk100mhz) begin
        if (clr) begin
            disp_digits <= 32'h0;
            blank       <= 8'hFF;
            cursor      <= 3'd7;
            mode        <= 2'b00;
            id_valid    <= 1'b0;
        end else begin
            disp_digits <= digits_s;
            blank       <= blank_s;
            cursor      <= cursor_r;
            mode        <= state_r;
            id_valid    <= id_valid_r;
        end
    end

endmodule

// File: tb/tb_id_entry_ctrl.sv
// Directed bench for id_entry_ctrl: table of key vectors plus hand-written
// scroll and reset sequences, SCROLL_DIV reduced to 4.
module tb_id_entry_ctrl;

    logic        clk100mhz;
    logic        clr;
    logic        key_wei_p, key_shuzi_p, key_enter_p, key_input_p, key_disp_p;
    logic [31:0] disp_digits;
    logic [7:0]  blank;
    logic [2:0]  cursor;
    logic [1:0]  mode;
    logic        id_valid;

    int total = 0;
    int bad   = 0;

    id_entry_ctrl #(.DIGITS(8), .SCROLL_DIV(4)) dut (
        .clk100mhz   (clk100mhz),
        .clr         (clr),
        .key_wei_p   (key_wei_p),
        .key_shuzi_p (key_shuzi_p),
        .key_enter_p (key_enter_p),
        .key_input_p (key_input_p),
        .key_disp_p  (key_disp_p),
        .disp_digits (disp_digits),
        .blank       (blank),
        .cursor      (cursor),
        .mode        (mode),
        .id_valid    (id_valid)
    );

    initial clk100mhz = 1'b0;
    always #5 clk100mhz = ~clk100mhz;

    // keys = {input, enter, disp, wei, shuzi}
    typedef struct {
        logic [4:0]  keys;
        int          rep;
        logic [1:0]  e_mode;
        logic [2:0]  e_cur;
        logic [31:0] e_dig;
        logic [7:0]  e_blank;
        logic        e_valid;
    } vec_t;

    vec_t vec[10];

    task automatic set_keys(input logic [4:0] k);
        {key_input_p, key_enter_p, key_disp_p, key_wei_p, key_shuzi_p} = k;
    endtask

    // Hold keys for rep cycles, drop them, let outputs settle one cycle, sample at negedge
    task automatic apply(input logic [4:0] k, input logic c, input int rep);
        @(negedge clk100mhz);
        set_keys(k);
        clr = c;
        repeat (rep) @(posedge clk100mhz);
        @(negedge clk100mhz);
        set_keys(5'b00000);
        clr = 1'b0;
        @(posedge clk100mhz);
        @(negedge clk100mhz);
    endtask

    task automatic check(input string name, input logic [1:0] m, input logic [2:0] c,
                         input logic [31:0] d, input logic [7:0] b, input logic v);
        total++;
        if (mode !== m) begin
            bad++;
            $display("FAIL %s mode: got %b want %b", name, mode, m);
        end
        total++;
        if (cursor !== c) begin
            bad++;
            $display("FAIL %s cursor: got %0d want %0d", name, cursor, c);
        end
        total++;
        if (disp_digits !== d) begin
            bad++;
            $display("FAIL %s digits: got %h want %h", name, disp_digits, d);
        end
        total++;
        if (blank !== b) begin
            bad++;
            $display("FAIL %s blank: got %h want %h", name, blank, b);
        end
        total++;
        if (id_valid !== v) begin
            bad++;
            $display("FAIL %s id_valid: got %b want %b", name, id_valid, v);
        end
    endtask

    initial begin
        vec[0] = '{5'b00100, 1,  2'b00, 3'd7, 32'h0000_0000, 8'hFF, 1'b0}; // disp with no ID
        vec[1] = '{5'b00010, 1,  2'b00, 3'd7, 32'h0000_0000, 8'hFF, 1'b0}; // wei ignored in IDLE
        vec[2] = '{5'b10000, 1,  2'b01, 3'd7, 32'h0000_0000, 8'h00, 1'b0}; // enter INPUT
        vec[3] = '{5'b00001, 3,  2'b01, 3'd7, 32'h3000_0000, 8'h00, 1'b0};
        vec[4] = '{5'b00010, 1,  2'b01, 3'd6, 32'h3000_0000, 8'h00, 1'b0};
        vec[5] = '{5'b00001, 12, 2'b01, 3'd6, 32'h3200_0000, 8'h00, 1'b0}; // 9->0 wrap
        vec[6] = '{5'b00010, 7,  2'b01, 3'd7, 32'h3200_0000, 8'h00, 1'b0}; // 0->7 wrap
        vec[7] = '{5'b00010, 8,  2'b01, 3'd7, 32'h3200_0000, 8'h00, 1'b0}; // full lap
        vec[8] = '{5'b00100, 1,  2'b01, 3'd7, 32'h3200_0000, 8'h00, 1'b0}; // disp ignored in INPUT
        vec[9] = '{5'b01000, 1,  2'b00, 3'd7, 32'h0000_0000, 8'hFF, 1'b1}; // commit

        clr = 1'b0;
        set_keys(5'b00000);

        // Reset with random keys held
        @(negedge clk100mhz);
        clr = 1'b1;
        set_keys(5'($urandom_range(0, 31)));
        @(posedge clk100mhz);
        @(negedge clk100mhz);
        set_keys(5'($urandom_range(0, 31)));
        @(posedge clk100mhz);
        @(negedge clk100mhz);
        check("reset", 2'b00, 3'd7, 32'h0, 8'hFF, 1'b0);
        clr = 1'b0;
        set_keys(5'b00000);
        @(posedge clk100mhz);
        @(negedge clk100mhz);
        check("reset_hold", 2'b00, 3'd7, 32'h0, 8'hFF, 1'b0);

        for (int i = 0; i < 10; i++) begin
            apply(vec[i].keys, 1'b0, vec[i].rep);
            check($sformatf("vec%0d", i), vec[i].e_mode, vec[i].e_cur, vec[i].e_dig,
                  vec[i].e_blank, vec[i].e_valid);
        end

        // Scrolling: one nibble step every 4 cycles, full cycle after 32
        apply(5'b00100, 1'b0, 1);
        check("disp_enter", 2'b10, 3'd7, 32'h3200_0000, 8'h00, 1'b1);
        repeat (4) @(posedge clk100mhz);
        @(negedge clk100mhz);
        check("scroll1", 2'b10, 3'd7, 32'h2000_0003, 8'h00, 1'b1);
        repeat (4) @(posedge clk100mhz);
        @(negedge clk100mhz);
        check("scroll2", 2'b10, 3'd7, 32'h0000_0032, 8'h00, 1'b1);
        repeat (24) @(posedge clk100mhz);
        @(negedge clk100mhz);
        check("scroll8", 2'b10, 3'd7, 32'h3200_0000, 8'h00, 1'b1);

        // DISP -> INPUT, then simultaneous input+enter re-clears without committing
        apply(5'b10000, 1'b0, 1);
        check("disp_to_input", 2'b01, 3'd7, 32'h0, 8'h00, 1'b1);
        apply(5'b00001, 1'b0, 2);
        apply(5'b00010, 1'b0, 1);
        check("edit2", 2'b01, 3'd6, 32'h2000_0000, 8'h00, 1'b1);
        apply(5'b11000, 1'b0, 1);
        check("input_enter", 2'b01, 3'd7, 32'h0, 8'h00, 1'b1);

        // New ID, show it, then clr during DISP
        apply(5'b00001, 1'b0, 5);
        apply(5'b01000, 1'b0, 1);
        check("commit5", 2'b00, 3'd7, 32'h0, 8'hFF, 1'b1);
        apply(5'b00100, 1'b0, 1);
        check("disp5", 2'b10, 3'd7, 32'h5000_0000, 8'h00, 1'b1);
        apply(5'b00000, 1'b1, 1);
        check("clr_disp", 2'b00, 3'd7, 32'h0, 8'hFF, 1'b0);
        apply(5'b00100, 1'b0, 1);
        check("disp_after_clr", 2'b00, 3'd7, 32'h0, 8'hFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
